// File: rtl/wb_stream_reader_ctrl.sv
// Wishbone burst-write master that drains a FWFT FIFO into a circular memory buffer.
// One enable pulse writes buf_size bytes as a series of burst_size-word incrementing bursts.
module wb_stream_reader_ctrl #(
    parameter int unsigned WB_AW         = 32,
    parameter int unsigned WB_DW         = 32,
    parameter int unsigned FIFO_AW       = 0,
    parameter int unsigned MAX_BURST_LEN = 0
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    // Wishbone master
    output logic [WB_AW-1:0]     wbm_adr_o,
    output logic [WB_DW-1:0]     wbm_dat_o,
    output logic [WB_DW/8-1:0]   wbm_sel_o,
    output logic                 wbm_we_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic [2:0]           wbm_cti_o,
    output logic [1:0]           wbm_bte_o,
    input  logic [WB_DW-1:0]     wbm_dat_i,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i,
    input  logic                 wbm_rty_i,
    // source FIFO
    input  logic [WB_DW-1:0]     fifo_d,
    output logic                 fifo_rd,
    input  logic [FIFO_AW:0]     fifo_cnt,
    // configuration and status
    input  logic                 enable,
    input  logic [WB_AW-1:0]     start_adr,
    input  logic [WB_AW-1:0]     buf_size,
    input  logic [WB_AW-1:0]     burst_size,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned BCW  = (MAX_BURST_LEN > 0) ? $clog2(MAX_BURST_LEN + 1) : 1;
    localparam int unsigned CMPW = (FIFO_AW + 1 > WB_AW) ? FIFO_AW + 1 : WB_AW;

    if (FIFO_AW == 0) begin : g_bad_fifo_aw
        $error("wb_stream_reader_ctrl: FIFO_AW must be non-zero");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACTIVE = 2'b01
    } state_t;

    state_t           state;
    logic [WB_AW-1:0] adr;
    logic [BCW-1:0]   burst_cnt;

    logic             active;
    logic             fifo_ready;
    logic             burst_last;
    logic             adr_last;
    logic             beat_done;
    logic [WB_AW-1:0] buf_words;

    // Data bus and the low two byte-address bits of the buffer size are never consumed.
    logic unused_ok;
    assign unused_ok = ^{wbm_dat_i, buf_size[1:0]};

    assign active     = (state == S_ACTIVE);
    assign buf_words  = WB_AW'(buf_size[WB_AW-1:2]);
    assign fifo_ready = CMPW'(fifo_cnt) >= CMPW'(burst_size);
    assign burst_last = (WB_AW'(burst_cnt) == burst_size - WB_AW'(1));
    assign adr_last   = (adr == buf_words - WB_AW'(1));
    // A beat completes only on a clean ack; err and rty both suppress it.
    assign beat_done  = wbm_ack_i & ~wbm_err_i & ~wbm_rty_i;

    assign wbm_cyc_o = active;
    assign wbm_stb_o = active;
    assign wbm_we_o  = active;
    assign wbm_sel_o = '1;
    assign wbm_bte_o = 2'b00;
    assign wbm_dat_o = fifo_d;
    assign wbm_adr_o = start_adr + {adr[WB_AW-3:0], 2'b00};
    assign wbm_cti_o = !active   ? 3'b000 :
                       burst_last ? 3'b111 : 3'b010;
    assign fifo_rd   = active & beat_done;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            err       <= 1'b0;
            adr       <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    burst_cnt <= '0;
                    if (enable && !busy) begin
                        busy <= 1'b1;
                        err  <= 1'b0;
                    end else if (busy && fifo_ready) begin
                        state <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (wbm_err_i) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        err       <= 1'b1;
                        adr       <= '0;
                        burst_cnt <= '0;
                    end else if (beat_done) begin
                        adr <= adr_last ? '0 : adr + WB_AW'(1);
                        if (burst_last) begin
                            state     <= S_IDLE;
                            burst_cnt <= '0;
                            if (adr_last) begin
                                busy <= 1'b0;
                            end
                        end else begin
                            burst_cnt <= burst_cnt + BCW'(1);
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

endmodule
